// File: rtl/prbs_test_ctrl.sv
// prbs_test_ctrl: sends PATTERN n times to a pattern detector, then waits for a detection or a timeout.
// Optional macro PTC_ABORT_EN adds an abort input that ends a run early with pass=0.
`default_nettype none

module prbs_test_ctrl #(
  parameter logic [31:0] PATTERN = 32'hAABBCCDD,
  parameter int unsigned TO_W    = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [7:0]      n,
  input  logic [TO_W-1:0] timeout,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            pattern_detected,
`ifdef PTC_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic            pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      r_idx;
  logic [7:0]      r_rep;
  logic [7:0]      r_n;
  logic [TO_W-1:0] r_timeout;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_seen;
  logic            w_abort;

`ifdef PTC_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  function automatic logic [7:0] pat_byte(input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = PATTERN[31:24];
      2'd1:    b = PATTERN[23:16];
      2'd2:    b = PATTERN[15:8];
      default: b = PATTERN[7:0];
    endcase
    return b;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      r_idx      <= '0;
      r_rep      <= '0;
      r_n        <= '0;
      r_timeout  <= '0;
      r_wait_cnt <= '0;
      r_seen     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            r_n        <= n;
            r_timeout  <= timeout;
            r_idx      <= '0;
            r_rep      <= '0;
            r_wait_cnt <= '0;
            r_seen     <= 1'b0;
            pass       <= 1'b0;
            if (n == 8'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_SEND;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_data  <= pat_byte(2'd0);
            end
          end
        end

        S_SEND: begin
          if (pattern_detected) r_seen <= 1'b1;
          if (w_abort) begin
            state     <= S_DONE;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
          end else if (out_ready) begin
            // out_valid is always high here, so ready alone marks a transfer
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_rep <= r_rep + 8'd1;
            if (r_idx == 2'd3 && r_rep == r_n - 8'd1) begin
              state      <= S_WAIT;
              out_valid  <= 1'b0;
              out_data   <= '0;
              r_wait_cnt <= '0;
            end else begin
              out_data <= pat_byte(r_idx + 2'd1);
            end
          end
        end

        S_WAIT: begin
          if (pattern_detected) r_seen <= 1'b1;
          if (w_abort) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else if (r_seen || pattern_detected) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (r_wait_cnt == r_timeout) begin
            // compare before increment so an all-ones limit cannot wrap
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prbs_test_ctrl.sv
// tb_prbs_test_ctrl: randomized scoreboard bench; expected bytes and run results come from a run-level model.
`default_nettype none

module tb_prbs_test_ctrl;

  localparam logic [31:0] c_pat = 32'hAABBCCDD;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [7:0]  n;
  logic [15:0] timeout;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        pattern_detected;
  logic        busy;
  logic        done;
  logic        pass;
`ifdef PTC_ABORT_EN
  logic        abort;
`endif

  prbs_test_ctrl #(.PATTERN(c_pat), .TO_W(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .n(n),
    .timeout(timeout),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pattern_detected(pattern_detected),
`ifdef PTC_ABORT_EN
    .abort(abort),
`endif
    .busy(busy),
    .done(done),
    .pass(pass)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [7:0] exp_bytes[$];
  bit         exp_pass[$];
  int         exp_wl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model_byte(input int i);
    logic [31:0] w;
    w = c_pat >> (8 * (3 - (i % 4)));
    return w[7:0];
  endfunction

  // Monitor: pops expectations whenever the DUT presents a byte or a result
  bit         hold_pend = 1'b0;
  logic [7:0] hold_data = '0;
  int         wait_seen = 0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (hold_pend) begin
        chk("no_bubble", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {24'd0, out_data}, {24'd0, hold_data});
      end
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) chk("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
        else chk("byte", {24'd0, out_data}, {24'd0, exp_bytes.pop_front()});
      end
      if (!out_valid) chk("idle_data_zero", {24'd0, out_data}, 32'd0);
      if (busy && !out_valid) wait_seen++;
      if (done) begin
        chk("done_not_busy", {31'd0, busy}, 32'd0);
        if (exp_pass.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          chk("pass", {31'd0, pass}, {31'd0, exp_pass.pop_front()});
          chk("wait_cycles", wait_seen, exp_wl.pop_front());
        end
        wait_seen = 0;
      end
      hold_pend = out_valid && !out_ready && !RST;
      hold_data = out_data;
      if (RST) wait_seen = 0;
    end
  end

  task automatic chk_all_zero(input string nm);
    chk(nm, {20'd0, out_data, out_valid, busy, done, pass}, 32'd0);
  endtask

  // mode: 0 none, 1 detect at WAIT cycle k, 2 detect at SEND cycle k
  // rdy_pct < 0 toggles out_ready each SEND cycle
  task automatic do_run(input int nn, input int to, input int mode, input int k,
                        input int rdy_pct, input int rst_at, input int abort_at);
    int  sent = 0, wcnt = 0, scnt = 0, cyc = 0, how = 0, nb, limit;
    bit  tog = 1'b0, ep = 1'b0;
    int  ewl = 0;
    if (rst_at >= 0) nb = rst_at + 1;
    else if (abort_at >= 0) nb = abort_at + 1;
    else nb = 4 * nn;
    for (int i = 0; i < nb; i++) exp_bytes.push_back(model_byte(i));
    if (rst_at < 0) begin
      if (nn == 0 || abort_at >= 0) begin ep = 0; ewl = 0; end
      else if (mode == 1 && k <= to) begin ep = 1; ewl = k + 1; end
      else if (mode == 2) begin ep = 1; ewl = 1; end
      else begin ep = 0; ewl = to + 1; end
      exp_pass.push_back(ep);
      exp_wl.push_back(ewl);
    end
    limit = 66000 + 600 * nn + 100;
    start = 1'b1; n = 8'(nn); timeout = 16'(to); out_ready = 1'b1;
    @(posedge CLK); #1;
    while (how == 0 && cyc < limit) begin
      start = 1'b0;
      pattern_detected = 1'b0;
      if (done) begin
        start = 1'b1;
        how = 1;
      end else begin
        if (busy && !out_valid) begin
          if (mode == 1 && wcnt == k) pattern_detected = 1'b1;
          wcnt++;
        end
        if (out_valid) begin
          if (mode == 2 && scnt == k) pattern_detected = 1'b1;
          scnt++;
          if (rst_at >= 0 || abort_at >= 0) out_ready = 1'b1;
          else if (rdy_pct < 0) begin tog = ~tog; out_ready = tog; end
          else out_ready = ($urandom_range(99) < rdy_pct);
          if (rst_at >= 0 && sent == rst_at) begin RST = 1'b1; how = 2; end
`ifdef PTC_ABORT_EN
          if (abort_at >= 0 && sent == abort_at) abort = 1'b1;
`endif
          if (out_ready) sent++;
        end
        if (busy && $urandom_range(7) == 0) begin
          start = 1'b1; n = 8'($urandom); timeout = 16'($urandom);
        end
      end
      @(posedge CLK); #1;
      cyc++;
`ifdef PTC_ABORT_EN
      if (abort) begin
        abort = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd1);
        chk("abort_pass", {31'd0, pass}, 32'd0);
      end
`endif
    end
    start = 1'b0;
    pattern_detected = 1'b0;
    if (how == 1) begin
      chk("done_start_ignored", {30'd0, busy, out_valid}, 32'd0);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("pass_hold", {31'd0, pass}, {31'd0, ep});
    end else if (how == 2) begin
      chk_all_zero("reset_mid_send");
      RST = 1'b0;
    end else begin
      chk("run_timeout", cyc, 32'hFFFF_FFFF);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      exp_bytes.delete(); exp_pass.delete(); exp_wl.delete();
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; n = '0; timeout = '0;
    out_ready = 1'b0; pattern_detected = 1'b0;
`ifdef PTC_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset_state");
    RST = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK); #1;

    do_run(1, 10, 1, 1, 100, -1, -1);  // detect at second WAIT cycle
    do_run(3, 5, 0, 0, 100, -1, -1);   // timeout after 6 WAIT cycles
    do_run(2, 9, 0, 0, -1, -1, -1);    // ready toggling
    do_run(0, 4, 0, 0, 100, -1, -1);   // empty run
    do_run(2, 3, 0, 0, 100, 2, -1);    // reset on 3rd byte
    do_run(1, 0, 0, 0, 100, -1, -1);   // single WAIT cycle
    do_run(2, 0, 1, 0, 70, -1, -1);
    do_run(2, 4, 2, 3, 60, -1, -1);    // detection during SEND
    for (int r = 0; r < 30; r++) begin
      int nn, to, mode, k;
      nn   = $urandom_range(0, 6);
      to   = $urandom_range(0, 12);
      mode = $urandom_range(0, 2);
      k    = (mode == 1) ? $urandom_range(0, 14) : $urandom_range(0, 3);
      do_run(nn, to, mode, k, $urandom_range(20, 100), -1, -1);
    end
    do_run(1, 65535, 0, 0, 100, -1, -1); // all-ones limit must not wrap
`ifdef PTC_ABORT_EN
    do_run(4, 20, 0, 0, 100, -1, 4);
    do_run(1, 8, 0, 0, 100, -1, -1);
`endif

    repeat (5) @(posedge CLK);
    #1;
    chk("bytes_left", exp_bytes.size(), 32'd0);
    chk("results_left", exp_pass.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prbs_test_ctrl.md
PRBS_TEST_CTRL -- requirements
Module: prbs_test_ctrl

Interface
REQ-001 SHALL have parameter PATTERN, default 32'hAABBCCDD: 4-byte header, transmitted MSB byte first.
REQ-002 SHALL have parameter TO_W, default 16: width of the timeout counter and of the timeout port.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle run request; honoured only in IDLE.
REQ-006 SHALL have port n  input  8  header repetition count, sampled when start is accepted.
REQ-007 SHALL have port timeout  input  TO_W  WAIT-phase cycle limit, sampled when start is accepted.
REQ-008 SHALL have port out_data  output  8  header byte sent to the detector datapath.
REQ-009 SHALL have port out_valid  output  1  out_data valid; drives the detector's data_valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts a byte when out_valid && out_ready.
REQ-011 SHALL have port pattern_detected  input  1  detection flag from the pattern detector.
REQ-012 SHALL have port busy  output  1  high in SEND and WAIT.
REQ-013 SHALL have port done  output  1  one-cycle pulse at the end of a run.
REQ-014 SHALL have port pass  output  1  run result; valid from the done cycle until the next accepted start.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, WAIT and DONE.
REQ-016 IDLE: start=1 SHALL latch n and timeout, clear pass and the seen flag, and enter SEND next cycle; if n==0, SHALL enter DONE instead, with pass=0 and no bytes sent.
REQ-017 SEND SHALL hold out_valid=1, with out_data = PATTERN byte[idx] (idx 0..3 = bits 31:24 .. 7:0).
REQ-018 SEND: a transfer (out_valid && out_ready) SHALL advance idx; idx wraps 3->0 and increments the repetition counter.
REQ-019 With out_ready=0, out_data and idx SHALL hold and out_valid SHALL stay 1 (no bubble), so the detector is not reset.
REQ-020 Exactly 4*n bytes SHALL be transferred; the cycle after the last transfer SHALL enter WAIT with out_valid=0.
REQ-021 The seen flag SHALL set on any cycle in SEND or WAIT where pattern_detected=1, and SHALL hold until the next accepted start.
REQ-022 WAIT: if seen or pattern_detected is set, SHALL go to DONE with pass=1; else if wait_cnt==timeout, SHALL go to DONE with pass=0; else wait_cnt+1.
REQ-023 wait_cnt SHALL clear on WAIT entry; timeout=0 gives exactly one WAIT cycle; timeout=all-ones SHALL not wrap before expiring.
REQ-024 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE; start in DONE SHALL be ignored.
REQ-025 start while busy SHALL be ignored, with no effect on latched n or timeout.
REQ-026 out_data SHALL be 8'h00 whenever out_valid=0.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE and clear idx, the repetition counter, wait_cnt and seen.
REQ-028 RST=1 SHALL set out_valid=0, out_data=0, busy=0, done=0 and pass=0.
REQ-029 RST asserted mid-SEND or mid-WAIT SHALL abort silently, with no done pulse.

Configuration
REQ-030 Macro PTC_ABORT_EN SHALL add port abort (input, 1).
REQ-031 With PTC_ABORT_EN: abort=1 while busy SHALL drop out_valid next cycle and enter DONE with pass=0; abort SHALL take priority over detection and timeout in the same cycle, and SHALL be ignored in IDLE and DONE.
REQ-032 Without PTC_ABORT_EN: no abort port; runs end only by detection, timeout, or RST.

Verification
REQ-033 n=1, timeout=10, out_ready=1, start -> out_data AA,BB,CC,DD on 4 consecutive cycles, then WAIT; pattern_detected pulse at WAIT cycle 2 -> done=1 and pass=1 one cycle later.
REQ-034 n=3, timeout=5, no pattern_detected -> 12 bytes sent, 6 WAIT cycles, then done=1 with pass=0.
REQ-035 n=2, out_ready toggling 1,0,1,0 -> out_valid stays 1, each byte is held during ready=0, 8 transfers total, byte order preserved.
REQ-036 n=0, start -> out_valid is never 1; done=1 with pass=0 on the cycle after start.
REQ-037 RST=1 during the 3rd byte of SEND -> next cycle IDLE with all outputs 0 and no done pulse; a new start runs normally.
REQ-038 PTC_ABORT_EN, n=4, abort=1 at byte 5 -> out_valid=0 and done=1 with pass=0 the next cycle; repeat without the macro and confirm the abort port is absent.
